// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state codes and op encodings.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN (adds a runtime add/subtract select).
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/bit_fsub.sv
// One-bit full subtractor / full adder cell. Purely combinational; the borrow/carry
// flop lives in the parent so the cell can be reused every serial step.
module bit_fsub
    import serial_sub_pkg::*;
(
    input  logic ai_i,
    input  logic bi_i,
    input  logic ci_i,
    input  logic op_i,
    output logic d_o,
    output logic co_o
);

    logic a_eff;

    // Borrow-out is the carry-out majority with the minuend bit inverted.
    always_comb begin
        a_eff = (op_i == OP_ADD) ? ai_i : ~ai_i;
        d_o   = ai_i ^ bi_i ^ ci_i;
        co_o  = (a_eff & bi_i) | (a_eff & ci_i) | (bi_i & ci_i);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on input and output.
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN adds port op (0 = subtract, 1 = add).
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic         op,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    diff_q, diff_d;
    logic            br_q, br_d;
    logic            a_msb_q, a_msb_d;
    logic            b_msb_q, b_msb_d;
    logic            op_cur;
    logic            d_bit;
    logic            co_bit;

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic op_q, op_d;

    // Operation select is latched at accept so it cannot change mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_SUB;
        end else begin
            op_q <= op_d;
        end
    end

    assign op_d   = (state_q == IDLE && in_valid) ? op : op_q;
    assign op_cur = op_q;
`else
    assign op_cur = OP_SUB;
`endif

    bit_fsub u_bit_fsub (
        .ai_i (a_q[0]),
        .bi_i (b_q[0]),
        .ci_i (br_q),
        .op_i (op_cur),
        .d_o  (d_bit),
        .co_o (co_bit)
    );

    // Next-state logic: accept in IDLE, one serial step per RUN edge, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    a_msb_d = a[N-1];
                    b_msb_d = b[N-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d = {d_bit, diff_q[N-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = co_bit;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    // Outputs; ovf sign condition flips between subtract (signs differ) and add (signs match).
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        diff      = diff_q;
        bout      = br_q;
        ovf       = (a_msb_q ^ b_msb_q ^ op_cur) & (diff_q[N-1] ^ a_msb_q);
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (N=4): directed plan steps plus randomized operations
// checked against an arithmetic reference model.
module tb_serial_sub;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    serial_sub #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mbin,
                         input logic mop, output logic [N-1:0] ed, output logic eb,
                         output logic eo);
        int ua, ub, sa, sb, r, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= (1 << (N - 1))) ? ua - (1 << N) : ua;
        sb = (ub >= (1 << (N - 1))) ? ub - (1 << N) : ub;
        if (mop) begin
            r  = ua + ub + int'(mbin);
            sr = sa + sb + int'(mbin);
            eb = (r >= (1 << N));
        end else begin
            r  = ua - ub - int'(mbin);
            sr = sa - sb - int'(mbin);
            eb = (ua < ub + int'(mbin));
        end
        ed = N'(r & ((1 << N) - 1));
        eo = (sr < -(1 << (N - 1))) || (sr > (1 << (N - 1)) - 1);
    endtask

    // Called at a negedge; presents operands with in_valid held high.
    task automatic drive(input logic [N-1:0] da, input logic [N-1:0] db, input logic dbin,
                         input logic dop);
        a        = da;
        b        = db;
        bin      = dbin;
        op       = dop;
        in_valid = 1'b1;
    endtask

    // Called at a negedge with operands presented; ends at the negedge where out_valid rises.
    task automatic run_check(input string tag);
        logic [N-1:0] ed;
        logic         eb, eo;
        model(a, b, bin, op, ed, eb, eo);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy"}, {30'd0, in_ready, out_valid}, 32'd0);
        repeat (N - 1) @(negedge clk);
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {30'd0, in_ready, out_valid}, 32'd1);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    // Called at the negedge where out_valid is high; consumes the result.
    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    task automatic hold(input string tag, input int cycles);
        logic [N+1:0] snap;
        snap = {diff, bout, ovf};
        repeat (cycles) begin
            @(negedge clk);
            chk({tag, "_hold_hs"}, {30'd0, in_ready, out_valid}, 32'd1);
            chk({tag, "_hold_res"}, 32'({diff, bout, ovf}), 32'(snap));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        op        = 1'b0;
        #3;
        chk("reset_hs", {30'd0, in_ready, out_valid}, 32'd2);
        chk("reset_res", 32'({diff, bout, ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        drive(4'b0101, 4'b0011, 1'b0, 1'b0); run_check("p1");  consume("p1");
        drive(4'b0000, 4'b0001, 1'b0, 1'b0); run_check("p2a"); consume("p2a");
        drive(4'b0011, 4'b0011, 1'b1, 1'b0); run_check("p2b"); consume("p2b");
        drive(4'b1000, 4'b0001, 1'b0, 1'b0); run_check("p3a"); consume("p3a");
        drive(4'b0111, 4'b1111, 1'b0, 1'b0); run_check("p3b");

        // Backpressure: result held, new operands waiting but not accepted.
        drive(4'b1100, 4'b0101, 1'b1, 1'b0);
        hold("bp", 5);
        consume("bp");
        run_check("bp_next");
        consume("bp_next");

`ifdef SERIAL_SUB_ADD_MODE_EN
        drive(4'b0111, 4'b0001, 1'b0, 1'b1); run_check("add1"); consume("add1");
        drive(4'b1111, 4'b0001, 1'b0, 1'b1); run_check("add2"); consume("add2");
`endif

        for (int i = 0; i < 40; i++) begin
            logic rop;
`ifdef SERIAL_SUB_ADD_MODE_EN
            rop = 1'($urandom);
`else
            rop = 1'b0;
`endif
            drive(N'($urandom), N'($urandom), 1'($urandom), rop);
            run_check("rand");
            hold("rand", int'($urandom_range(0, 3)));
            consume("rand");
        end

        // Asynchronous reset after two RUN edges; leave a nonzero prior result first.
        drive(4'b0000, 4'b0001, 1'b0, 1'b0); run_check("pre_rst"); consume("pre_rst");
        drive(4'b1010, 4'b0011, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hs", {30'd0, in_ready, out_valid}, 32'd2);
        chk("arst_res", 32'({diff, bout, ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        drive(4'b0110, 4'b0010, 1'b0, 1'b0); run_check("post_rst");
        chk("post_rst_diff", 32'(diff), 32'b0100);
        consume("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- Counterpart to the team's parallel ripple-carry sum block: it subtracts instead of adds, and trades area for latency using a single borrow flop.
- Sits between operand producers and consumers behind valid/ready handshakes on both sides.

Parameters:
- N, 4, operand and result width in bits; legal range N >= 2.

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  N  minuend
- b  input  N  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  N  a - b - bin, modulo 2^N
- bout  output  1  borrow-out (unsigned a < b + bin)
- ovf  output  1  signed overflow

Behaviour:
- One clock domain; rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, diff=0, bout=0, ovf=0. Internal state is IDLE, counter=0, shift registers and borrow flop are 0.
- States are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: capture a and b into shift registers, bin into the borrow flop, and a[N-1], b[N-1] into sign flops. Clear the counter and go to RUN.
- RUN:
  - in_ready=0. On each edge, with ai, bi the current LSBs and br the borrow flop:
    - d = ai ^ bi ^ br
    - br' = (~ai & bi) | (~ai & br) | (bi & br)
  - d shifts into the MSB of the diff register (LSB-first fill). Operand registers shift right.
  - The counter increments; after the Nth RUN edge, go to DONE.
- DONE:
  - out_valid=1.
  - diff, bout (= final br) and ovf = (a_msb != b_msb) & (diff[N-1] != a_msb) stay stable until out_ready=1 at an edge, then go to IDLE.
- Latency: operands accepted at edge t0 give out_valid=1 after edge t0+N. Minimum initiation interval is N+2 cycles (IDLE, N x RUN, DONE).
- in_valid while in_ready=0 is ignored; the producer holds it. No accept happens in the cycle the result is consumed, because in_ready rises only in IDLE.
- out_ready while out_valid=0 has no effect.
- out_valid and in_ready are never both 1.
- In IDLE, diff/bout/ovf hold the last result (0 after reset). Consumers qualify them with out_valid.
- Reset mid-operation aborts immediately to reset values; the partial result is discarded.
- The counter is $clog2(N) bits wide and compares to N-1; there is no wrap beyond N.

Optional Feature:
- SERIAL_SUB_ADD_MODE_EN
- When defined:
  - Adds input port op (1 bit), sampled at accept: 0=subtract, 1=add.
  - Add mode uses s = ai ^ bi ^ c and c' = ai&bi | ai&c | bi&c.
  - bin acts as carry-in and bout reports carry-out.
  - ovf = (a_msb == b_msb) & (diff[N-1] != a_msb).
- When not defined: no op port; subtract only.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - op encoding constants (OP_SUB=1'b0, OP_ADD=1'b1)
- Sub-module bit_fsub:
  - Combinational one-bit full subtractor/adder cell (ai, bi, ci, op -> d, co).
  - Instanced once; the borrow/carry flop stays in the parent.

Test Plan (N=4):
- a=0101, b=0011, bin=0 -> after 4 RUN edges: out_valid=1, diff=0010, bout=0, ovf=0.
- a=0000, b=0001, bin=0 -> diff=1111, bout=1, ovf=0. Then a=0011, b=0011, bin=1 -> diff=1111, bout=1.
- a=1000, b=0001, bin=0 -> diff=0111, bout=0, ovf=1. Then a=0111, b=1111 -> diff=1000, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> diff/bout/ovf stable, in_ready=0, and a held in_valid is not accepted.
  - Then out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle; the held operands are accepted the cycle after.
- Reset: assert rst_n=0 asynchronously after 2 RUN edges -> all outputs take reset values without a clock edge. After release, in_ready=1 and a new a=0110, b=0010 gives diff=0100.
- With SERIAL_SUB_ADD_MODE_EN: op=1, a=0111, b=0001, bin=0 -> diff=1000, bout=0, ovf=1. Also op=1, a=1111, b=0001 -> diff=0000, bout=1, ovf=0.
